// File: rtl/pipelined_addsub.sv
// Skewed-carry pipelined adder/subtractor: each stage adds one SEG-bit slice
// with a carry-lookahead adder and passes its registered carry to the next.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NSTAGE = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of SEG");
  end

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Carry vector c[0..SEG] of one segment, every carry expanded to its
  // full generate/propagate sum-of-products (no ripple through c[i]).
  function automatic logic [SEG:0] cla_carries(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           ci);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < SEG; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int unsigned j = i; j > 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j-1]);
        pp     = pp & p[j-1];
      end
      c[i+1] = c[i+1] | (pp & ci);
    end
    return c;
  endfunction

  // Stage registers: operands shift down so the next slice sits at bit 0,
  // result slices shift in from the top so the last stage holds S in order.
  logic [WIDTH-1:0] a_r   [NSTAGE];
  logic [WIDTH-1:0] b_r   [NSTAGE];
  logic [WIDTH-1:0] s_r   [NSTAGE];
  logic             cy_r  [NSTAGE];
  logic             vld_r [NSTAGE];
  logic             ov_r;
  logic             z_r;
  logic             n_r;

  logic [WIDTH-1:0] a_in  [NSTAGE];
  logic [WIDTH-1:0] b_in  [NSTAGE];
  logic [WIDTH-1:0] s_in  [NSTAGE];
  logic             c_in  [NSTAGE];
  logic             v_in  [NSTAGE];

  logic [WIDTH-1:0] a_n   [NSTAGE];
  logic [WIDTH-1:0] b_n   [NSTAGE];
  logic [WIDTH-1:0] s_n   [NSTAGE];
  logic             cy_n  [NSTAGE];
  logic             v_n   [NSTAGE];
  logic             ov_n;
  logic             z_n;
  logic             n_n;

  logic             cin0;
  logic             advance;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_r[NSTAGE-1];
  assign S         = s_r[NSTAGE-1];
  assign C         = cy_r[NSTAGE-1];
  assign overflow  = ov_r;
  assign zero      = z_r;
  assign negative  = n_r;

  always_comb begin
    cin0 = 1'b0;
    case (op_e'(op))
      OP_ADD:  cin0 = 1'b0;
      OP_ADC:  cin0 = Cin;
      OP_SUB:  cin0 = 1'b1;
      OP_SBB:  cin0 = ~Cin;
      default: cin0 = 1'b0;
    endcase
  end

  always_comb begin
    a_in[0] = A;
    b_in[0] = op[1] ? ~B : B;
    s_in[0] = '0;
    c_in[0] = cin0;
    v_in[0] = in_valid;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      a_in[k] = a_r[k-1];
      b_in[k] = b_r[k-1];
      s_in[k] = s_r[k-1];
      c_in[k] = cy_r[k-1];
      v_in[k] = vld_r[k-1];
    end
  end

  always_comb begin : stage_eval
    logic [SEG:0]   c;
    logic [SEG-1:0] seg;
    logic [SEG:0]   last_c;
    last_c = '0;
    c      = '0;
    seg    = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      c      = cla_carries(a_in[k][SEG-1:0], b_in[k][SEG-1:0], c_in[k]);
      seg    = a_in[k][SEG-1:0] ^ b_in[k][SEG-1:0] ^ c[SEG-1:0];
      a_n[k] = a_in[k] >> SEG;
      b_n[k] = b_in[k] >> SEG;
      s_n[k] = (s_in[k] >> SEG) | (WIDTH'(seg) << (WIDTH - SEG));
      cy_n[k] = c[SEG];
      v_n[k]  = v_in[k];
      last_c  = c;
    end
    ov_n = last_c[SEG] ^ last_c[SEG-1];
    z_n  = (s_n[NSTAGE-1] == '0);
    n_n  = s_n[NSTAGE-1][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        s_r[k]   <= '0;
        cy_r[k]  <= 1'b0;
        vld_r[k] <= 1'b0;
      end
      ov_r <= 1'b0;
      z_r  <= 1'b0;
      n_r  <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        a_r[k]   <= a_n[k];
        b_r[k]   <= b_n[k];
        s_r[k]   <= s_n[k];
        cy_r[k]  <= cy_n[k];
        vld_r[k] <= v_n[k];
      end
      ov_r <= ov_n;
      z_r  <= z_n;
      n_r  <= n_n;
    end
  end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; SHALL be a multiple of SEG.
REQ-002 Parameter SEG, 8, bits added per pipeline stage; NSTAGE = WIDTH/SEG; WIDTH % SEG != 0 SHALL fail elaboration.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set present on A, B, Cin, op.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 A  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  carry-in (ADC) or borrow-in (SBB); ignored for ADD/SUB.
REQ-010 op  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBB.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 S  output  WIDTH  result.
REQ-014 C  output  1  carry-out of MSB (raw adder carry; for SUB/SBB 1 = no borrow).
REQ-015 overflow  output  1  signed overflow.
REQ-016 zero  output  1  S == 0.
REQ-017 negative  output  1  S[WIDTH-1].

Function
REQ-018 Arithmetic SHALL be: ADD A+B+0; ADC A+B+Cin; SUB A+~B+1; SBB A+~B+~Cin (A-B-Cin), all modulo 2^WIDTH.
REQ-019 Stage k (0..NSTAGE-1) SHALL add segment bits [SEG*k+SEG-1 : SEG*k] using the registered carry from stage k-1 (stage 0 uses the op-derived carry-in); segment adder is carry-lookahead.
REQ-020 Unprocessed upper operand segments and completed lower result segments SHALL be carried forward in pipeline registers (skewed datapath).
REQ-021 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-022 Global advance = !out_valid || out_ready; in_ready SHALL equal advance; when advance=0 every stage register holds.
REQ-023 Each stage SHALL carry a valid bit; bubbles advance with data (no bubble collapsing).
REQ-024 Latency SHALL be exactly NSTAGE advancing cycles from accept to out_valid; with out_ready held high, throughput is one result per cycle.
REQ-025 Results SHALL emerge in acceptance order; no result is dropped or duplicated under any out_ready pattern.
REQ-026 overflow SHALL equal carry into MSB XOR carry out of MSB of the final stage.
REQ-027 zero and negative SHALL be computed from the full WIDTH result in the final stage and registered with S.
REQ-028 S, C, overflow, zero, negative SHALL hold stable while out_valid && !out_ready.
REQ-029 in_valid while in_ready=0 SHALL not be accepted; the source holds its operands.
REQ-030 With NSTAGE = 1 the block SHALL behave as a single-register add/sub with latency 1.

Reset
REQ-031 While rst=1 at a clock edge, all stage valid bits, S, C, overflow, zero, negative SHALL become 0; in_ready SHALL read 1 the cycle after.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none appear at the output afterward.
REQ-033 Inputs during rst=1 SHALL be ignored (no accept).

Verification (WIDTH=32, SEG=8, latency 4)
REQ-034 ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> 4 cycles later S=0x80000000, C=0, overflow=1, negative=1, zero=0.
REQ-035 SUB 5-5 -> S=0, C=1, zero=1; SUB 0-1 -> S=0xFFFFFFFF, C=0, overflow=0, negative=1.
REQ-036 ADC 0xFFFFFFFF + 0 + Cin=1 -> S=0, C=1, zero=1, overflow=0; SBB 0x10 - 0x01 - Cin=1 -> S=0x0E, C=1.
REQ-037 10 back-to-back random ops, out_ready low for 3 cycles mid-stream -> in_ready low those cycles, outputs frozen, all 10 results correct and in order against a reference model.
REQ-038 3 ops in flight, rst=1 for 1 cycle -> out_valid=0 afterward, no stale result emerges; next accepted op returns after 4 cycles.
